dsp_simd2x_int9xuint8_cascade_add_stim_ref: RTL and testbench
=============================================================

Name: dsp_simd2x_int9xuint8_cascade_add_stim_ref

Overview:
Upstream stimulus generator and golden model for the DSP SIMD 2x INT9xUINT8 cascade-add unit.
- Drives operand vectors into the DUV.
- Computes the expected ca/cb sums.
- Delays the expected sums and operands by the DUV latency so they arrive at the scoreboard aligned with the DUV outputs.
- Sequences the scoreboard_reset/scoreboard_en controls that the downstream scoreboard consumes.

Parameters:
DUV_LATENCY, 4, cycles from DUV input to DUV result (legal range ≥1)
TEST_VECTORS, 1024, vectors issued per run (≥1)
LFSR_SEED, 32'hACE1_2022, seed for the operand LFSR; the coeff LFSR uses ~LFSR_SEED

Ports:
clk  in  1  clock
aresetn  in  1  reset, synchronous active-low (sampled on posedge clk only)
start  in  1  begin a run; ignored unless state is IDLE
mode  in  1  0 = LFSR random, 1 = corner-case table
a_duv  out  8x[0:1]  unsigned lane-A operands to DUV
b_duv  out  8x[0:1]  unsigned lane-B operands to DUV
coeff_duv  out  signed 9x[0:1]  coefficients to DUV
in_valid  out  1  DUV operands valid this cycle
ca_mul_ref  out  signed 18  a[0]*coeff[0] + a[1]*coeff[1], aligned with DUV output
cb_mul_ref  out  signed 18  b[0]*coeff[0] + b[1]*coeff[1], aligned with DUV output
a_ref, b_ref  out  8x[0:1]  operands delayed by DUV_LATENCY
coeff_ref  out  signed 9x[0:1]  coefficients delayed by DUV_LATENCY
scoreboard_en  out  1  compare enable, aligned with ref outputs
scoreboard_reset  out  1  one-cycle statistics clear
busy  out  1  high in CLEAR/RUN/DRAIN
done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (aresetn=0 at posedge): state IDLE; all outputs 0; delay-line valid bits cleared; counters 0; LFSRs loaded with seeds. Reset mid-run aborts immediately; no scoreboard_en may appear after reset.
- FSM states:
  - IDLE: start=1 → CLEAR.
  - CLEAR: exactly 1 cycle. scoreboard_reset=1; LFSRs reloaded; vector counter=0. → RUN.
  - RUN: one vector per cycle, in_valid=1, counter++. After the vector with counter==TEST_VECTORS-1 is issued → DRAIN.
  - DRAIN: in_valid=0 for DUV_LATENCY cycles while the delay line flushes. → DONE.
  - DONE: 1 cycle, done=1. → IDLE.
- start asserted outside IDLE is ignored. start held high re-triggers only after returning to IDLE, i.e. back-to-back runs are legal.
- Latency: a vector presented with in_valid in cycle t produces ref outputs with scoreboard_en=1 in cycle t+DUV_LATENCY.
- Delay line: DUV_LATENCY-stage shift register carrying {valid, a, b, coeff, ca, cb}.
  - The expected sum is computed combinationally from the issued vector and enters stage 1 in the same edge as the DUV input register.
  - When scoreboard_en=0, ref data outputs hold their last value; their value is not checked.
- Arithmetic: each operand is zero-extended to 10-bit signed and multiplied by the 9-bit signed coeff. The two products are summed into 18-bit signed.
  - Range is -130560..+130050, so there is no overflow and no saturation.
- Random mode:
  - Operand LFSR and coeff LFSR are both 32-bit Galois, taps 32'h8020_0003, right shift, and advance once per issued vector only.
  - Operand fields: a[0]=op[7:0], a[1]=op[15:8], b[0]=op[23:16], b[1]=op[31:24].
  - Coeff fields: coeff[0]=cf[8:0], coeff[1]=cf[24:16].
- Corner mode: index = counter[1:0].
  - 0: a={255,255}, b={255,255}, c={-256,-256} → ca=cb=-130560
  - 1: a={255,255}, b={0,0}, c={255,255} → ca=130050, cb=0
  - 2: a={0,0}, b={255,255}, c={-256,255} → ca=0, cb=-255
  - 3: a={1,128}, b={128,1}, c={-1,2} → ca=255, cb=-126
- mode is sampled in CLEAR and held for the whole run.
- Output counts per run: exactly TEST_VECTORS scoreboard_en cycles and exactly one scoreboard_reset cycle.
- scoreboard_reset and scoreboard_en are never high in the same cycle.

Test Plan:
1. Reset, start=1 for 1 cycle, mode=1, TEST_VECTORS=4, DUV_LATENCY=4 → scoreboard_reset high at cycle 1; in_valid cycles 2-5; scoreboard_en cycles 6-9 with ca_mul_ref = -130560, 130050, 0, 255 and cb_mul_ref = -130560, 0, -255, -126; done pulse at cycle 10; busy low from cycle 10.
2. Random mode, TEST_VECTORS=1024, ideal delayed-multiplier DUV model, downstream scoreboard attached → test_count=1024, error_count=0; two runs with the same seed produce identical ref streams.
3. aresetn=0 mid-RUN at vector 100, then released → all outputs 0, no scoreboard_en pulse afterwards; a new start gives a full 1024-vector run beginning from the seed vector.
4. start pulsed during RUN and DRAIN → ignored; exactly TEST_VECTORS scoreboard_en cycles; single done pulse.
5. DUV_LATENCY=1, TEST_VECTORS=1 → in_valid at cycle t, scoreboard_en at t+1, done at t+2.
6. start held high continuously → back-to-back runs, each preceded by one scoreboard_reset cycle; IDLE lasts 1 cycle between runs.

Source files
------------

// File: rtl/dsp_simd2x_int9xuint8_cascade_add_stim_ref.sv
// Stimulus generator and golden model for the SIMD 2x INT9xUINT8 cascade-add DUV.
// Issues LFSR or corner-case vectors and delays expected sums to line up with the DUV result.
module dsp_simd2x_int9xuint8_cascade_add_stim_ref #(
    parameter int unsigned DUV_LATENCY  = 4,
    parameter int unsigned TEST_VECTORS = 1024,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_2022
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   start,
    input  logic                   mode,
    output logic [0:1][7:0]        a_duv,
    output logic [0:1][7:0]        b_duv,
    output logic signed [0:1][8:0] coeff_duv,
    output logic                   in_valid,
    output logic signed [17:0]     ca_mul_ref,
    output logic signed [17:0]     cb_mul_ref,
    output logic [0:1][7:0]        a_ref,
    output logic [0:1][7:0]        b_ref,
    output logic signed [0:1][8:0] coeff_ref,
    output logic                   scoreboard_en,
    output logic                   scoreboard_reset,
    output logic                   busy,
    output logic                   done
);

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [0:1][7:0] a;
        logic [0:1][7:0] b;
        logic [0:1][8:0] c;
        logic [17:0]     ca;
        logic [17:0]     cb;
    } vec_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [31:0] op_q, op_d;
    logic [31:0] cf_q, cf_d;

    logic [DUV_LATENCY-1:0] pv_q, pv_d;
    vec_t                   pd_q [DUV_LATENCY];
    vec_t                   pd_d [DUV_LATENCY];

    vec_t               cur;
    logic signed [17:0] ea0, ea1, eb0, eb1, ec0, ec1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        op_d    = op_q;
        cf_d    = cf_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                mode_d  = mode;
                op_d    = LFSR_SEED;
                cf_d    = ~LFSR_SEED;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                op_d = lfsr_next(op_q);
                cf_d = lfsr_next(cf_q);
                if (cnt_q == TEST_VECTORS - 1) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DUV_LATENCY - 1) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Vector source and golden cascade sum; operands zero-extend, coeffs sign-extend to 18 bits.
    always_comb begin
        cur = '0;
        if (mode_q) begin
            case (cnt_q[1:0])
                2'd0: begin
                    cur.a = {8'd255, 8'd255};
                    cur.b = {8'd255, 8'd255};
                    cur.c = {9'h100, 9'h100};
                end
                2'd1: begin
                    cur.a = {8'd255, 8'd255};
                    cur.b = {8'd0, 8'd0};
                    cur.c = {9'd255, 9'd255};
                end
                2'd2: begin
                    cur.a = {8'd0, 8'd0};
                    cur.b = {8'd255, 8'd255};
                    cur.c = {9'h100, 9'd255};
                end
                default: begin
                    cur.a = {8'd1, 8'd128};
                    cur.b = {8'd128, 8'd1};
                    cur.c = {9'h1FF, 9'd2};
                end
            endcase
        end else begin
            cur.a = {op_q[7:0], op_q[15:8]};
            cur.b = {op_q[23:16], op_q[31:24]};
            cur.c = {cf_q[8:0], cf_q[24:16]};
        end
        ea0    = {10'b0, cur.a[0]};
        ea1    = {10'b0, cur.a[1]};
        eb0    = {10'b0, cur.b[0]};
        eb1    = {10'b0, cur.b[1]};
        ec0    = {{9{cur.c[0][8]}}, cur.c[0]};
        ec1    = {{9{cur.c[1][8]}}, cur.c[1]};
        cur.ca = ea0 * ec0 + ea1 * ec1;
        cur.cb = eb0 * ec0 + eb1 * ec1;
    end

    assign in_valid = (state_q == S_RUN);

    // Stage data only moves with a valid token, so the ref outputs hold between bursts.
    always_comb begin
        pv_d    = pv_q;
        pd_d    = pd_q;
        pv_d[0] = in_valid;
        pd_d[0] = in_valid ? cur : pd_q[0];
        for (int unsigned i = 1; i < DUV_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pv_q[i-1] ? pd_q[i-1] : pd_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            op_q    <= LFSR_SEED;
            cf_q    <= ~LFSR_SEED;
            pv_q    <= '0;
            for (int unsigned i = 0; i < DUV_LATENCY; i++) pd_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            op_q    <= op_d;
            cf_q    <= cf_d;
            pv_q    <= pv_d;
            for (int unsigned i = 0; i < DUV_LATENCY; i++) pd_q[i] <= pd_d[i];
        end
    end

    assign a_duv            = in_valid ? cur.a : '0;
    assign b_duv            = in_valid ? cur.b : '0;
    assign coeff_duv        = in_valid ? cur.c : '0;
    assign ca_mul_ref       = pd_q[DUV_LATENCY-1].ca;
    assign cb_mul_ref       = pd_q[DUV_LATENCY-1].cb;
    assign a_ref            = pd_q[DUV_LATENCY-1].a;
    assign b_ref            = pd_q[DUV_LATENCY-1].b;
    assign coeff_ref        = pd_q[DUV_LATENCY-1].c;
    assign scoreboard_en    = pv_q[DUV_LATENCY-1];
    assign scoreboard_reset = (state_q == S_CLEAR);
    assign busy             = (state_q == S_CLEAR) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done             = (state_q == S_DONE);

endmodule

// File: tb/tb_dsp_simd2x_int9xuint8_cascade_add_stim_ref.sv
// Bench for the cascade-add stimulus/reference generator: three instances cover the
// corner-table timing, the 1024-vector random run, and the minimum-latency case.
module tb_dsp_simd2x_int9xuint8_cascade_add_stim_ref;

    localparam logic [31:0] SEED = 32'hACE1_2022;
    localparam logic [31:0] TAPS = 32'h8020_0003;
    localparam int RL  = 4;
    localparam int RTV = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic aresetn;

    // s: latency 4, 4 vectors
    logic s_start, s_mode, s_iv, s_en, s_srst, s_busy, s_done;
    logic [0:1][7:0] s_a_duv, s_b_duv, s_a_ref, s_b_ref;
    logic [0:1][8:0] s_coeff_duv, s_coeff_ref;
    logic signed [17:0] s_ca, s_cb;
    // r: latency 4, 1024 vectors
    logic r_start, r_mode, r_iv, r_en, r_srst, r_busy, r_done;
    logic [0:1][7:0] r_a_duv, r_b_duv, r_a_ref, r_b_ref;
    logic [0:1][8:0] r_coeff_duv, r_coeff_ref;
    logic signed [17:0] r_ca, r_cb;
    // m: latency 1, 1 vector
    logic m_start, m_mode, m_iv, m_en, m_srst, m_busy, m_done;
    logic [0:1][7:0] m_a_duv, m_b_duv, m_a_ref, m_b_ref;
    logic [0:1][8:0] m_coeff_duv, m_coeff_ref;
    logic signed [17:0] m_ca, m_cb;

    dsp_simd2x_int9xuint8_cascade_add_stim_ref #(.DUV_LATENCY(4), .TEST_VECTORS(4), .LFSR_SEED(SEED)) u_s (
        .clk(clk), .aresetn(aresetn), .start(s_start), .mode(s_mode),
        .a_duv(s_a_duv), .b_duv(s_b_duv), .coeff_duv(s_coeff_duv), .in_valid(s_iv),
        .ca_mul_ref(s_ca), .cb_mul_ref(s_cb), .a_ref(s_a_ref), .b_ref(s_b_ref), .coeff_ref(s_coeff_ref),
        .scoreboard_en(s_en), .scoreboard_reset(s_srst), .busy(s_busy), .done(s_done));

    dsp_simd2x_int9xuint8_cascade_add_stim_ref #(.DUV_LATENCY(RL), .TEST_VECTORS(RTV), .LFSR_SEED(SEED)) u_r (
        .clk(clk), .aresetn(aresetn), .start(r_start), .mode(r_mode),
        .a_duv(r_a_duv), .b_duv(r_b_duv), .coeff_duv(r_coeff_duv), .in_valid(r_iv),
        .ca_mul_ref(r_ca), .cb_mul_ref(r_cb), .a_ref(r_a_ref), .b_ref(r_b_ref), .coeff_ref(r_coeff_ref),
        .scoreboard_en(r_en), .scoreboard_reset(r_srst), .busy(r_busy), .done(r_done));

    dsp_simd2x_int9xuint8_cascade_add_stim_ref #(.DUV_LATENCY(1), .TEST_VECTORS(1), .LFSR_SEED(SEED)) u_m (
        .clk(clk), .aresetn(aresetn), .start(m_start), .mode(m_mode),
        .a_duv(m_a_duv), .b_duv(m_b_duv), .coeff_duv(m_coeff_duv), .in_valid(m_iv),
        .ca_mul_ref(m_ca), .cb_mul_ref(m_cb), .a_ref(m_a_ref), .b_ref(m_b_ref), .coeff_ref(m_coeff_ref),
        .scoreboard_en(m_en), .scoreboard_reset(m_srst), .busy(m_busy), .done(m_done));

    typedef struct {
        logic [7:0] a0, a1, b0, b1;
        logic [8:0] c0, c1;
        int ca, cb, cyc;
    } exp_t;

    exp_t sbq[$];

    function automatic int sx9(input logic [8:0] v);
        return v[8] ? int'(v) - 512 : int'(v);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        if (s[0]) return (s >> 1) ^ TAPS;
        return s >> 1;
    endfunction

    function automatic exp_t model_vec(input logic md, input int idx, input logic [31:0] op, input logic [31:0] cf);
        exp_t e;
        e.cyc = 0;
        if (md) begin
            case (idx % 4)
                0: begin e.a0 = 255; e.a1 = 255; e.b0 = 255; e.b1 = 255; e.c0 = 9'h100; e.c1 = 9'h100; end
                1: begin e.a0 = 255; e.a1 = 255; e.b0 = 0;   e.b1 = 0;   e.c0 = 9'd255; e.c1 = 9'd255; end
                2: begin e.a0 = 0;   e.a1 = 0;   e.b0 = 255; e.b1 = 255; e.c0 = 9'h100; e.c1 = 9'd255; end
                default: begin e.a0 = 1; e.a1 = 128; e.b0 = 128; e.b1 = 1; e.c0 = 9'h1FF; e.c1 = 9'd2; end
            endcase
        end else begin
            e.a0 = op[7:0];   e.a1 = op[15:8];
            e.b0 = op[23:16]; e.b1 = op[31:24];
            e.c0 = cf[8:0];   e.c1 = cf[24:16];
        end
        e.ca = int'(e.a0) * sx9(e.c0) + int'(e.a1) * sx9(e.c1);
        e.cb = int'(e.b0) * sx9(e.c0) + int'(e.b1) * sx9(e.c1);
        return e;
    endfunction

    task automatic test_reset;
        aresetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_iv, s_en, s_srst, s_busy, s_done} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl_s: got %b expected 00000", {s_iv, s_en, s_srst, s_busy, s_done});
        end
        checks++;
        if ({s_a_duv, s_b_duv, s_coeff_duv, s_ca, s_cb, s_a_ref, s_b_ref, s_coeff_ref} !== '0) begin
            errors++; $display("FAIL reset_data_s: got %h expected 0", {s_a_duv, s_b_duv, s_coeff_duv, s_ca, s_cb});
        end
        checks++;
        if ({r_iv, r_en, r_srst, r_busy, r_done, r_ca, r_cb, r_a_ref, r_coeff_ref} !== '0) begin
            errors++; $display("FAIL reset_r: got %h expected 0", {r_iv, r_en, r_srst, r_busy, r_done, r_ca, r_cb});
        end
        aresetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_corner_timing;
        int eca[4] = '{-130560, 130050, 0, 255};
        int ecb[4] = '{-130560, 0, -255, -126};
        exp_t e;
        s_mode = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            checks++;
            if ({s_srst, s_iv, s_en, s_done, s_busy} !== {k == 1, k >= 2 && k <= 5, k >= 6 && k <= 9, k == 10, k >= 1 && k <= 9}) begin
                errors++; $display("FAIL corner_ctrl k=%0d: got srst/iv/en/done/busy=%b", k, {s_srst, s_iv, s_en, s_done, s_busy});
            end
            if (k >= 2 && k <= 5) begin
                e = model_vec(1'b1, k - 2, 32'd0, 32'd0);
                checks++;
                if ({s_a_duv, s_b_duv, s_coeff_duv} !== {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1}) begin
                    errors++; $display("FAIL corner_duv k=%0d: got %h expected %h", k, {s_a_duv, s_b_duv, s_coeff_duv}, {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1});
                end
            end
            if (k >= 6 && k <= 9) begin
                checks++;
                if (int'(s_ca) != eca[k-6] || int'(s_cb) != ecb[k-6]) begin
                    errors++; $display("FAIL corner_sum k=%0d: got ca=%0d cb=%0d expected ca=%0d cb=%0d", k, s_ca, s_cb, eca[k-6], ecb[k-6]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        int p;
        s_mode = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 33; k++) begin
            p = k % 11;
            checks++;
            if ({s_srst, s_en, s_done} !== {p == 1, p >= 6 && p <= 9, p == 10}) begin
                errors++; $display("FAIL b2b k=%0d: got srst/en/done=%b", k, {s_srst, s_en, s_done});
            end
            if (k == 33) s_start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (s_busy !== 1'b0 || s_srst !== 1'b0) begin
            errors++; $display("FAIL b2b_stop: got busy=%b srst=%b expected 0 0", s_busy, s_srst);
        end
    endtask

    task automatic test_min_latency;
        exp_t e;
        e = model_vec(1'b0, 0, SEED, ~SEED);
        m_mode = 1'b0;
        m_start = 1'b1;
        @(negedge clk);
        m_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            checks++;
            if ({m_srst, m_iv, m_en, m_done, m_busy} !== {k == 1, k == 2, k == 3, k == 4, k >= 1 && k <= 3}) begin
                errors++; $display("FAIL minlat_ctrl k=%0d: got srst/iv/en/done/busy=%b", k, {m_srst, m_iv, m_en, m_done, m_busy});
            end
            if (k == 2) begin
                checks++;
                if ({m_a_duv, m_b_duv, m_coeff_duv} !== {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1}) begin
                    errors++; $display("FAIL minlat_duv: got %h expected %h", {m_a_duv, m_b_duv, m_coeff_duv}, {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1});
                end
            end
            if (k == 3) begin
                checks++;
                if (int'(m_ca) != e.ca || int'(m_cb) != e.cb) begin
                    errors++; $display("FAIL minlat_sum: got ca=%0d cb=%0d expected ca=%0d cb=%0d", m_ca, m_cb, e.ca, e.cb);
                end
            end
            @(negedge clk);
        end
    endtask

    // Drives one run on instance r; model vectors are pushed as they issue and popped at scoreboard_en.
    task automatic score_run(input logic md, input int abort_at, input logic poke, output int n_en, output longint csum);
        exp_t e, g;
        logic [31:0] op, cf;
        int n_iv, n_rst, n_done;
        logic pk_run, pk_drain, done_busy;
        op = SEED; cf = ~SEED;
        n_iv = 0; n_rst = 0; n_done = 0; n_en = 0; csum = 0;
        pk_run = 0; pk_drain = 0; done_busy = 0;
        sbq.delete();
        @(negedge clk);
        r_mode = md;
        r_start = 1'b1;
        @(negedge clk);
        for (int cyc = 0; cyc < RTV + RL + 16; cyc++) begin
            r_start = 1'b0;
            checks++;
            if (r_srst && r_en) begin
                errors++; $display("FAIL srst_en_overlap cyc=%0d: got both high expected exclusive", cyc);
            end
            if (r_srst) n_rst++;
            if (r_iv) begin
                e = model_vec(md, n_iv, op, cf);
                e.cyc = cyc;
                checks++;
                if ({r_a_duv, r_b_duv, r_coeff_duv} !== {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1}) begin
                    errors++; $display("FAIL duv_vec %0d: got %h expected %h", n_iv, {r_a_duv, r_b_duv, r_coeff_duv}, {e.a0, e.a1, e.b0, e.b1, e.c0, e.c1});
                end
                sbq.push_back(e);
                n_iv++;
                op = lfsr_step(op);
                cf = lfsr_step(cf);
            end
            if (r_en) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++; $display("FAIL sb_underflow cyc=%0d: got scoreboard_en with empty queue", cyc);
                end else begin
                    g = sbq.pop_front();
                    if (int'(r_ca) != g.ca || int'(r_cb) != g.cb || cyc != g.cyc + RL
                        || {r_a_ref, r_b_ref, r_coeff_ref} !== {g.a0, g.a1, g.b0, g.b1, g.c0, g.c1}) begin
                        errors++; $display("FAIL ref_out %0d: got ca=%0d cb=%0d cyc=%0d expected ca=%0d cb=%0d cyc=%0d", n_en, r_ca, r_cb, cyc, g.ca, g.cb, g.cyc + RL);
                    end
                end
                n_en++;
                csum += longint'(r_ca) * (n_en + 1) + longint'(r_cb);
            end
            if (r_done) begin
                n_done++;
                done_busy = r_busy;
            end
            if (abort_at > 0 && n_iv == abort_at) begin
                aresetn = 1'b0;
                @(negedge clk);
                aresetn = 1'b1;
                checks++;
                if ({r_iv, r_en, r_srst, r_busy, r_done, r_a_duv, r_ca, r_cb, r_a_ref, r_b_ref, r_coeff_ref} !== '0) begin
                    errors++; $display("FAIL abort_zero: got %h expected 0", {r_iv, r_en, r_srst, r_busy, r_done, r_ca, r_cb});
                end
                for (int j = 0; j < RL + 4; j++) begin
                    @(negedge clk);
                    checks++;
                    if (r_en !== 1'b0 || r_busy !== 1'b0) begin
                        errors++; $display("FAIL abort_quiet j=%0d: got en=%b busy=%b expected 0 0", j, r_en, r_busy);
                    end
                end
                return;
            end
            if (poke && n_iv == 1) r_mode = ~md;
            if (poke && n_iv == 50 && !pk_run) begin r_start = 1'b1; pk_run = 1'b1; end
            if (poke && n_iv == RTV && !r_iv && r_busy && !pk_drain) begin r_start = 1'b1; pk_drain = 1'b1; end
            if (r_done) break;
            @(negedge clk);
        end
        r_start = 1'b0;
        r_mode = md;
        checks++;
        if (n_done != 1 || n_rst != 1 || n_en != RTV || sbq.size() != 0 || done_busy !== 1'b0) begin
            errors++; $display("FAIL run_counts: got done=%0d srst=%0d en=%0d left=%0d busy_at_done=%b expected 1 1 %0d 0 0",
                               n_done, n_rst, n_en, sbq.size(), done_busy, RTV);
        end
    endtask

    task automatic test_random;
        int n1, n2;
        longint c1, c2;
        score_run(1'b0, 0, 1'b0, n1, c1);
        score_run(1'b0, 0, 1'b0, n2, c2);
        checks++;
        if (c1 != c2 || n1 != n2) begin
            errors++; $display("FAIL repeat_stream: got sum %0d/%0d count %0d/%0d expected equal", c1, c2, n1, n2);
        end
    endtask

    task automatic test_reset_mid_run;
        int n;
        longint c;
        score_run(1'b0, 100, 1'b0, n, c);
        score_run(1'b0, 0, 1'b0, n, c);
    endtask

    task automatic test_start_ignored;
        int n;
        longint c;
        score_run(1'b1, 0, 1'b1, n, c);
        score_run(1'b0, 0, 1'b1, n, c);
    endtask

    initial begin
        aresetn = 1'b0;
        s_start = 1'b0; s_mode = 1'b0;
        r_start = 1'b0; r_mode = 1'b0;
        m_start = 1'b0; m_mode = 1'b0;
        test_reset;
        test_corner_timing;
        test_back_to_back;
        test_min_latency;
        test_random;
        test_reset_mid_run;
        test_start_ignored;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
